// File: rtl/alu_pkg.sv
// Shared definitions for alu_issuer: opcodes, flag bit positions, FSM states, illegal-op test.
// No timing of its own; backpressure is not applicable to a package.
package alu_pkg;

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_XOR  = 4'b0010;
    localparam logic [3:0] OP_NOR  = 4'b0011;
    localparam logic [3:0] OP_NOT  = 4'b0100;
    localparam logic [3:0] OP_PASS = 4'b0101;
    localparam logic [3:0] OP_ADD  = 4'b0110;
    localparam logic [3:0] OP_SUB  = 4'b0111;
    localparam logic [3:0] OP_SLT  = 4'b1000;
    localparam logic [3:0] OP_SLL  = 4'b1010;
    localparam logic [3:0] OP_SRL  = 4'b1011;
    localparam logic [3:0] OP_ROL  = 4'b1100;
    localparam logic [3:0] OP_SRA  = 4'b1101;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    function automatic logic op_illegal(input logic [3:0] op);
        return (op == 4'b1001) || (op == 4'b1110) || (op == 4'b1111);
    endfunction

endpackage

// File: rtl/alu_issuer.sv
// Registered valid/ready front-end for the 32-bit combinational ALU with a sticky status-flag register.
// Latency: legal op responds 2 edges after acceptance, illegal op 1 edge; one legal op per 2 cycles.
// Backpressure: response held until rsp_ready; req_ready low in EXEC and in RESP while rsp_ready=0. ALU_ISSUER_CARRY_CHAIN_EN enables carry chaining.
module alu_issuer
    import alu_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int TAG_W  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [3:0]        req_op,
    input  logic [DATA_W-1:0] req_a,
    input  logic [DATA_W-1:0] req_b,
    input  logic              req_cin,
    input  logic [TAG_W-1:0]  req_tag,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [3:0]        alu_sel,
    output logic              alu_cin,
    input  logic [DATA_W-1:0] alu_y,
    input  logic              alu_cout,
    input  logic              alu_neg,
    input  logic              alu_zero,
    input  logic              alu_ovf,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_y,
    output logic [3:0]        rsp_flags,
    output logic [TAG_W-1:0]  rsp_tag,
    output logic              rsp_err,
    output logic [3:0]        status_flags
);

    state_t      r_state;
    state_t      w_state_nxt;
    logic        w_accept;
    logic        w_illegal;
    logic        w_cin;
    logic [3:0]  w_flags;

    assign w_illegal = op_illegal(req_op);
    assign w_accept  = req_valid & req_ready;
    assign w_flags   = {alu_neg, alu_zero, alu_cout, alu_ovf};

`ifdef ALU_ISSUER_CARRY_CHAIN_EN
    // Acceptance never coincides with EXEC, so status_flags already holds the latest capture.
    assign w_cin = (req_cin && (req_op == OP_ADD || req_op == OP_SUB)) ? status_flags[FLAG_C] : req_cin;
`else
    assign w_cin = req_cin;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        req_ready   = 1'b0;
        rsp_valid   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    w_state_nxt = w_illegal ? ST_RESP : ST_EXEC;
                end
            end
            ST_EXEC: begin
                w_state_nxt = ST_RESP;
            end
            ST_RESP: begin
                rsp_valid = 1'b1;
                req_ready = rsp_ready;
                if (rsp_ready) begin
                    if (req_valid) begin
                        w_state_nxt = w_illegal ? ST_RESP : ST_EXEC;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Acceptance and EXEC capture are mutually exclusive, so the two updates never collide.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            alu_a        <= '0;
            alu_b        <= '0;
            alu_sel      <= '0;
            alu_cin      <= 1'b0;
            rsp_y        <= '0;
            rsp_flags    <= '0;
            rsp_tag      <= '0;
            rsp_err      <= 1'b0;
            status_flags <= '0;
        end else begin
            if (w_accept) begin
                alu_a   <= req_a;
                alu_b   <= req_b;
                alu_sel <= req_op;
                alu_cin <= w_cin;
                rsp_tag <= req_tag;
                if (w_illegal) begin
                    rsp_y     <= '0;
                    rsp_flags <= '0;
                    rsp_err   <= 1'b1;
                end
            end
            if (r_state == ST_EXEC) begin
                rsp_y        <= alu_y;
                rsp_flags    <= w_flags;
                rsp_err      <= 1'b0;
                status_flags <= w_flags;
            end
        end
    end

endmodule

// File: tb/tb_alu_issuer.sv
// Randomized self-checking bench for alu_issuer with a behavioural ALU beside it and a request-level reference model.
module tb_alu_issuer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_op;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic        req_cin;
    logic [3:0]  req_tag;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [3:0]  alu_sel;
    logic        alu_cin;
    logic [31:0] alu_y;
    logic        alu_cout;
    logic        alu_neg;
    logic        alu_zero;
    logic        alu_ovf;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_y;
    logic [3:0]  rsp_flags;
    logic [3:0]  rsp_tag;
    logic        rsp_err;
    logic [3:0]  status_flags;

    int          n_chk = 0;
    int          n_err = 0;
    logic [3:0]  m_status;
    logic [35:0] w_alu;

    always #5 clk = ~clk;

    alu_issuer #(.DATA_W(32), .TAG_W(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b), .req_cin(req_cin), .req_tag(req_tag),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_cin(alu_cin),
        .alu_y(alu_y), .alu_cout(alu_cout), .alu_neg(alu_neg), .alu_zero(alu_zero), .alu_ovf(alu_ovf),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_y(rsp_y), .rsp_flags(rsp_flags),
        .rsp_tag(rsp_tag), .rsp_err(rsp_err), .status_flags(status_flags)
    );

    // Returns {N,Z,C,V,y}.
    function automatic logic [35:0] alu_fn(input logic [3:0] op, input logic [31:0] a,
                                           input logic [31:0] b, input logic cin);
        logic [32:0] s;
        logic [31:0] y;
        logic        c;
        logic        v;
        logic [4:0]  sh;
        s  = '0;
        y  = '0;
        c  = 1'b0;
        v  = 1'b0;
        sh = b[4:0];
        case (op)
            4'd0:  y = a & b;
            4'd1:  y = a | b;
            4'd2:  y = a ^ b;
            4'd3:  y = ~(a | b);
            4'd4:  y = ~a;
            4'd5:  y = a;
            4'd6: begin
                s = {1'b0, a} + {1'b0, b} + {32'd0, cin};
                y = s[31:0];
                c = s[32];
                v = (a[31] == b[31]) && (y[31] != a[31]);
            end
            4'd7: begin
                s = {1'b0, a} + {1'b0, ~b} + {32'd0, cin};
                y = s[31:0];
                c = s[32];
                v = (a[31] != b[31]) && (y[31] != a[31]);
            end
            4'd8:  y = {31'd0, $signed(a) < $signed(b)};
            4'd10: y = a << sh;
            4'd11: y = a >> sh;
            4'd12: y = (a << sh) | (a >> (6'd32 - {1'b0, sh}));
            4'd13: y = $unsigned($signed(a) >>> sh);
            default: y = '0;
        endcase
        return {y[31], (y == 32'd0), c, v, y};
    endfunction

    always_comb begin
        w_alu = alu_fn(alu_sel, alu_a, alu_b, alu_cin);
    end
    assign alu_y    = w_alu[31:0];
    assign alu_neg  = w_alu[35];
    assign alu_zero = w_alu[34];
    assign alu_cout = w_alu[33];
    assign alu_ovf  = w_alu[32];

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Issue one request from IDLE or RESP (rsp_ready decides) and check it through to its response.
    task automatic xfer(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic cin, input logic [3:0] tag);
        logic        ill;
        logic        ecin;
        logic [35:0] r;
        ill = (op == 4'd9) || (op >= 4'd14);
        ecin = cin;
`ifdef ALU_ISSUER_CARRY_CHAIN_EN
        if (cin && (op == 4'd6 || op == 4'd7)) ecin = m_status[1];
`endif
        r = ill ? 36'd0 : alu_fn(op, a, b, ecin);
        req_valid = 1'b1;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        req_cin   = cin;
        req_tag   = tag;
        #1;
        chk("req_ready_accept", 64'(req_ready), 64'd1);
        @(negedge clk);
        req_valid = 1'b0;
        chk("alu_sel", 64'(alu_sel), 64'(op));
        chk("alu_a", 64'(alu_a), 64'(a));
        chk("alu_b", 64'(alu_b), 64'(b));
        chk("alu_cin", 64'(alu_cin), 64'(ecin));
        if (!ill) begin
            chk("exec_no_valid", 64'(rsp_valid), 64'd0);
            m_status = r[35:32];
            @(negedge clk);
        end
        chk("rsp_valid", 64'(rsp_valid), 64'd1);
        chk("rsp_err", 64'(rsp_err), 64'(ill));
        chk("rsp_y", 64'(rsp_y), 64'(r[31:0]));
        chk("rsp_flags", 64'(rsp_flags), 64'(r[35:32]));
        chk("rsp_tag", 64'(rsp_tag), 64'(tag));
        chk("status_flags", 64'(status_flags), 64'(m_status));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0]  op;
        logic [31:0] held_y;
        m_status  = 4'd0;
        rst_n     = 1'b0;
        req_valid = 1'b1;
        req_op    = 4'd6;
        req_a     = 32'h1234_5678;
        req_b     = 32'h1;
        req_cin   = 1'b1;
        req_tag   = 4'd9;
        rsp_ready = 1'b1;

        repeat (2) @(negedge clk);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_rsp_y", 64'(rsp_y), 64'd0);
        chk("rst_rsp_flags", 64'(rsp_flags), 64'd0);
        chk("rst_rsp_tag", 64'(rsp_tag), 64'd0);
        chk("rst_rsp_err", 64'(rsp_err), 64'd0);
        chk("rst_status", 64'(status_flags), 64'd0);
        chk("rst_alu_a", 64'(alu_a), 64'd0);
        chk("rst_alu_b", 64'(alu_b), 64'd0);
        chk("rst_alu_sel", 64'(alu_sel), 64'd0);
        chk("rst_alu_cin", 64'(alu_cin), 64'd0);
        req_valid = 1'b0;
        rst_n     = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", 64'(req_ready), 64'd1);
        chk("post_rst_no_rsp", 64'(rsp_valid), 64'd0);

        // Signed overflow on add.
        xfer(4'd6, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 4'd5);
        chk("add_y", 64'(rsp_y), 64'h8000_0000);
        chk("add_flags", 64'(rsp_flags), 64'b1001);
        @(negedge clk);

        // Illegal ops leave status_flags alone.
        xfer(4'b1001, 32'hDEAD_BEEF, 32'h1, 1'b0, 4'd3);
        chk("ill_status_kept", 64'(status_flags), 64'b1001);
        xfer(4'b1110, 32'h1, 32'h1, 1'b0, 4'd4);
        xfer(4'b1111, 32'h1, 32'h1, 1'b1, 4'd6);
        @(negedge clk);

        // Backpressure with a request waiting behind the response.
        rsp_ready = 1'b0;
        xfer(4'd7, 32'h0000_0005, 32'h0000_0009, 1'b1, 4'd7);
        held_y    = alu_fn(4'd7, 32'h5, 32'h9, 1'b1) >> 0;
        req_valid = 1'b1;
        req_op    = 4'd2;
        req_a     = 32'hF0F0_0000;
        req_b     = 32'h0FF0_0000;
        req_tag   = 4'd8;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_valid", 64'(rsp_valid), 64'd1);
            chk("bp_y", 64'(rsp_y), 64'(held_y));
            chk("bp_tag", 64'(rsp_tag), 64'd7);
            chk("bp_ready_low", 64'(req_ready), 64'd0);
            chk("bp_alu_sel_held", 64'(alu_sel), 64'd7);
        end
        rsp_ready = 1'b1;
        xfer(4'd2, 32'hF0F0_0000, 32'h0FF0_0000, 1'b0, 4'd8);

        // Back-to-back random legal ops, chained from RESP.
        for (int i = 0; i < 10; i++) begin
            op = 4'($urandom_range(0, 12));
            if (op >= 4'd9) op = op + 4'd1;
            xfer(op, $urandom, (i % 3 == 0) ? 32'($urandom_range(0, 40)) : $urandom,
                 1'($urandom_range(0, 1)), 4'(i));
        end
        @(negedge clk);

        // Carry chaining.
        xfer(4'd6, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 4'd10);
        chk("cc_carry_set", 64'(status_flags[1]), 64'd1);
        xfer(4'd6, 32'h0, 32'h0, 1'b1, 4'd11);
        chk("cc_y_one", 64'(rsp_y), 64'd1);
        xfer(4'd6, 32'h0, 32'h0, 1'b0, 4'd12);
        chk("cc_y_zero", 64'(rsp_y), 64'd0);
        @(negedge clk);

        // Reset while in EXEC discards the op.
        req_valid = 1'b1;
        req_op    = 4'd6;
        req_a     = 32'h8000_0000;
        req_b     = 32'h8000_0000;
        req_cin   = 1'b0;
        req_tag   = 4'd13;
        @(negedge clk);
        req_valid = 1'b0;
        rst_n     = 1'b0;
        @(negedge clk);
        rst_n    = 1'b1;
        m_status = 4'd0;
        chk("rst_exec_no_rsp", 64'(rsp_valid), 64'd0);
        chk("rst_exec_status", 64'(status_flags), 64'd0);
        @(negedge clk);
        chk("rst_exec_still_idle", 64'(rsp_valid), 64'd0);
        chk("rst_exec_ready", 64'(req_ready), 64'd1);

        // Reset while in RESP discards the pending response.
        rsp_ready = 1'b0;
        xfer(4'd0, 32'hFF00_FF00, 32'h0F0F_0F0F, 1'b0, 4'd14);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n    = 1'b1;
        m_status = 4'd0;
        chk("rst_resp_no_rsp", 64'(rsp_valid), 64'd0);
        chk("rst_resp_y", 64'(rsp_y), 64'd0);
        rsp_ready = 1'b1;
        xfer(4'd1, 32'h0000_00F0, 32'h0000_000F, 1'b0, 4'd15);
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
